// File: rtl/regfile_dump_serializer.sv
// Streams every architectural register (x0 first, LSB first) to the UART TX byte interface.
// Borrows register-file read port B while busy; x0 is always sent as zero.
module regfile_dump_serializer #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              done_o
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NB - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                tx_valid_q, tx_valid_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rd_addr_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_addr_q  <= rd_addr_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_addr_d  = rd_addr_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d     = '0;
          rd_addr_d = '0;
          state_d   = S_READ;
        end
      end
      S_READ: state_d = S_LATCH;
      S_LATCH: begin
        // x0 reads as zero regardless of what the BRAM word holds
        shreg_d    = (idx_q == '0) ? '0 : rd_data_i;
        byte_cnt_d = '0;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_valid_q && tx_ready_i) begin
          shreg_d    = shreg_q >> 8;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            tx_valid_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d     = idx_q + 1'b1;
              rd_addr_d = idx_q + 1'b1;
              state_d   = S_READ;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q == S_READ) || (state_q == S_LATCH) || (state_q == S_SEND);
  assign rd_req_o   = busy_o;
  assign rd_addr_o  = rd_addr_q;
  assign tx_data_o  = shreg_q[7:0];
  assign tx_valid_o = tx_valid_q;
  assign done_o     = (state_q == S_DONE);

endmodule
